// File: rtl/uart_mem_cmd_decoder_if.sv
// Bus bundle between the UART/memory debug front end and its environment.
// master: the command decoder (drives memory requests and tx bytes).
// slave : the UART and the memories around it.
interface uart_mem_cmd_decoder_if;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        enable;
   logic        write_mem_req;
   logic        target_mem_type;
   logic [8:0]  target_addr;
   logic        rw_flag;
   logic [31:0] uart_rx_data_in;
   logic        instr_mem_tx_data_ready;
   logic [41:0] instr_mem_tx_data;
   logic        data_mem_tx_data_ready;
   logic [41:0] data_mem_tx_data;

   modport master (
      input  rx_byte, rx_valid, tx_ready,
      input  instr_mem_tx_data_ready, instr_mem_tx_data,
      input  data_mem_tx_data_ready, data_mem_tx_data,
      output tx_byte, tx_valid, enable, write_mem_req,
      output target_mem_type, target_addr, rw_flag, uart_rx_data_in
   );

   modport slave (
      output rx_byte, rx_valid, tx_ready,
      output instr_mem_tx_data_ready, instr_mem_tx_data,
      output data_mem_tx_data_ready, data_mem_tx_data,
      input  tx_byte, tx_valid, enable, write_mem_req,
      input  target_mem_type, target_addr, rw_flag, uart_rx_data_in
   );
endinterface

// File: rtl/uart_mem_cmd_decoder.sv
// Host-side debug front end: assembles UART rx bytes into memory read/write
// and CPU halt/run commands, issues them to the instruction/data memories,
// and serializes read responses (or error bytes) back to the UART.
// Optional feature macro: WRITE_ACK_EN -- when defined, a completed WRITE,
// HALT or RUN answers with a single 0xA5 byte.
module uart_mem_cmd_decoder #(
   parameter int RX_TIMEOUT = 100000,
   parameter int RD_TIMEOUT = 16
) (
   input logic                    clk,
   input logic                    reset,
   uart_mem_cmd_decoder_if.master bus
);

   localparam int RxW = $clog2(RX_TIMEOUT + 1);
   localparam int RdW = $clog2(RD_TIMEOUT + 1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_HALT  = 2'b10;
   localparam logic [1:0] OP_RUN   = 2'b11;

   localparam logic [47:0] ERR_BYTE = {8'hEE, 40'h0};
   localparam logic [47:0] ACK_BYTE = {8'hA5, 40'h0};

   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_RD, SEND} state_e;

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic        memType_q, memType_d;
   logic [8:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  byteCnt_q, byteCnt_d;
   logic [RxW-1:0] rxTimer_q, rxTimer_d;
   logic [RdW-1:0] rdTimer_q, rdTimer_d;
   logic [47:0] shift_q, shift_d;
   logic [2:0]  txCnt_q, txCnt_d;
   logic        enable_q, enable_d;
   logic        req_q, req_d;
   logic        tgtType_q, tgtType_d;
   logic [8:0]  tgtAddr_q, tgtAddr_d;
   logic        rw_q, rw_d;
   logic [31:0] tgtData_q, tgtData_d;

   logic        rdReady;
   logic [41:0] rdData;
   logic        rxExpired;
   logic        rdExpired;

   // Only the memory addressed by the outstanding read is listened to.
   assign rdReady   = tgtType_q ? bus.instr_mem_tx_data_ready : bus.data_mem_tx_data_ready;
   assign rdData    = tgtType_q ? bus.instr_mem_tx_data       : bus.data_mem_tx_data;
   // A byte arriving on the expiry cycle wins, hence the rx_valid qualifier.
   assign rxExpired = !bus.rx_valid && (rxTimer_q == RxW'(RX_TIMEOUT - 1));
   assign rdExpired = (rdTimer_q == RdW'(RD_TIMEOUT - 1));

   assign bus.tx_valid        = (state_q == SEND);
   assign bus.tx_byte         = shift_q[47:40];
   assign bus.enable          = enable_q;
   assign bus.write_mem_req   = req_q;
   assign bus.target_mem_type = tgtType_q;
   assign bus.target_addr     = tgtAddr_q;
   assign bus.rw_flag         = rw_q;
   assign bus.uart_rx_data_in = tgtData_q;

   // State register; reset abandons any packet or transmission in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: packet assembly, issue, response wait and byte send.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               if (bus.rx_byte[7:6] == OP_READ || bus.rx_byte[7:6] == OP_WRITE) begin
                  state_d = GET_ADDR;
               end else begin
`ifdef WRITE_ACK_EN
                  state_d = SEND;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         GET_ADDR: begin
            if (bus.rx_valid) begin
               state_d = (op_q == OP_WRITE) ? GET_DATA : ISSUE;
            end else if (rxExpired) begin
               state_d = IDLE;
            end
         end
         GET_DATA: begin
            if (bus.rx_valid && byteCnt_q == 2'd3) begin
               state_d = ISSUE;
            end else if (rxExpired) begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (enable_q) begin
               state_d = SEND;
            end else if (op_q == OP_WRITE) begin
`ifdef WRITE_ACK_EN
               state_d = SEND;
`else
               state_d = IDLE;
`endif
            end else begin
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (rdReady || rdExpired) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ready && txCnt_q == 3'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath/output next values for each state.
   always_comb begin
      op_d      = op_q;
      memType_d = memType_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      byteCnt_d = byteCnt_q;
      rxTimer_d = rxTimer_q;
      rdTimer_d = rdTimer_q;
      shift_d   = shift_q;
      txCnt_d   = txCnt_q;
      enable_d  = enable_q;
      req_d     = 1'b0;
      tgtType_d = tgtType_q;
      tgtAddr_d = tgtAddr_q;
      rw_d      = rw_q;
      tgtData_d = tgtData_q;
      unique case (state_q)
         IDLE: begin
            rxTimer_d = '0;
            if (bus.rx_valid) begin
               op_d      = bus.rx_byte[7:6];
               memType_d = bus.rx_byte[5];
               addr_d    = {bus.rx_byte[0], 8'h00};
               if (bus.rx_byte[7:6] == OP_HALT) begin
                  enable_d = 1'b0;
               end
               if (bus.rx_byte[7:6] == OP_RUN) begin
                  enable_d = 1'b1;
               end
`ifdef WRITE_ACK_EN
               if (bus.rx_byte[7] == 1'b1) begin
                  shift_d = ACK_BYTE;
                  txCnt_d = 3'd1;
               end
`endif
            end
         end
         GET_ADDR: begin
            if (bus.rx_valid) begin
               addr_d    = {addr_q[8], bus.rx_byte};
               byteCnt_d = 2'd0;
               rxTimer_d = '0;
            end else begin
               rxTimer_d = rxTimer_q + 1'b1;
            end
         end
         GET_DATA: begin
            if (bus.rx_valid) begin
               wdata_d   = {wdata_q[23:0], bus.rx_byte};
               byteCnt_d = byteCnt_q + 2'd1;
               rxTimer_d = '0;
            end else begin
               rxTimer_d = rxTimer_q + 1'b1;
            end
         end
         ISSUE: begin
            rdTimer_d = '0;
            if (enable_q) begin
               shift_d = ERR_BYTE;
               txCnt_d = 3'd1;
            end else begin
               req_d     = 1'b1;
               tgtType_d = memType_q;
               tgtAddr_d = addr_q;
               rw_d      = (op_q == OP_WRITE);
               if (op_q == OP_WRITE) begin
                  tgtData_d = wdata_q;
`ifdef WRITE_ACK_EN
                  shift_d   = ACK_BYTE;
                  txCnt_d   = 3'd1;
`endif
               end
            end
         end
         WAIT_RD: begin
            if (rdReady) begin
               shift_d = {6'b0, rdData};
               txCnt_d = 3'd6;
            end else if (rdExpired) begin
               shift_d = ERR_BYTE;
               txCnt_d = 3'd1;
            end else begin
               rdTimer_d = rdTimer_q + 1'b1;
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               shift_d = {shift_q[39:0], 8'h00};
               txCnt_d = txCnt_q - 3'd1;
            end
         end
         default: ;
      endcase
   end

   // Datapath/output registers; the CPU comes out of reset running.
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_q      <= OP_READ;
         memType_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         byteCnt_q <= '0;
         rxTimer_q <= '0;
         rdTimer_q <= '0;
         shift_q   <= '0;
         txCnt_q   <= '0;
         enable_q  <= 1'b1;
         req_q     <= 1'b0;
         tgtType_q <= 1'b0;
         tgtAddr_q <= '0;
         rw_q      <= 1'b0;
         tgtData_q <= '0;
      end else begin
         op_q      <= op_d;
         memType_q <= memType_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         byteCnt_q <= byteCnt_d;
         rxTimer_q <= rxTimer_d;
         rdTimer_q <= rdTimer_d;
         shift_q   <= shift_d;
         txCnt_q   <= txCnt_d;
         enable_q  <= enable_d;
         req_q     <= req_d;
         tgtType_q <= tgtType_d;
         tgtAddr_q <= tgtAddr_d;
         rw_q      <= rw_d;
         tgtData_q <= tgtData_d;
      end
   end

endmodule

// File: tb/tb_uart_mem_cmd_decoder.sv
// Directed self-checking bench for uart_mem_cmd_decoder. Expectations for
// the 0xA5 acknowledge follow the WRITE_ACK_EN macro of the build.
module tb_uart_mem_cmd_decoder;

   localparam int RX_TO = 40;
   localparam int RD_TO = 16;

   logic clk = 1'b0;
   logic reset;

   int total = 0;
   int bad = 0;
   int reqCount = 0;
   logic       capType;
   logic [8:0] capAddr;
   logic       capRw;
   logic [31:0] capData;

   uart_mem_cmd_decoder_if bus ();

   uart_mem_cmd_decoder #(.RX_TIMEOUT(RX_TO), .RD_TIMEOUT(RD_TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Record every cycle the request strobe is high and what it addressed.
   always @(negedge clk) begin
      if (bus.write_mem_req === 1'b1) begin
         reqCount = reqCount + 1;
         capType  = bus.target_mem_type;
         capAddr  = bus.target_addr;
         capRw    = bus.rw_flag;
         capData  = bus.uart_rx_data_in;
      end
   end

   // One comparison: count it, and count and report it when it differs.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one rx byte for a single cycle.
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for a tx byte, hold tx_ready low for 'stall' cycles, then accept it.
   task automatic recvByte(input string tag, input logic [7:0] expected, input int stall);
      int waited = 0;
      while (bus.tx_valid !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (bus.tx_valid !== 1'b1) begin
         checkOutput({tag, "_tx_valid_timeout"}, 64'(bus.tx_valid), 64'd1);
         return;
      end
      checkOutput(tag, 64'(bus.tx_byte), 64'(expected));
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         checkOutput({tag, "_held"}, 64'({bus.tx_valid, bus.tx_byte}), 64'({1'b1, expected}));
      end
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
   endtask

   // Wait (bounded) for the request strobe of a read.
   task automatic waitReq(input string tag);
      int waited = 0;
      while (bus.write_mem_req !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(tag, 64'(bus.write_mem_req), 64'd1);
   endtask

   int reqBase;

   initial begin
      bus.rx_byte = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
      bus.instr_mem_tx_data_ready = 1'b0;
      bus.instr_mem_tx_data = '0;
      bus.data_mem_tx_data_ready = 1'b0;
      bus.data_mem_tx_data = '0;
      reset = 1'b0;
      waitCycles(3);

      checkOutput("rst_enable", 64'(bus.enable), 64'd1);
      checkOutput("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
      checkOutput("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
      checkOutput("rst_req", 64'(bus.write_mem_req), 64'd0);
      checkOutput("rst_type", 64'(bus.target_mem_type), 64'd0);
      checkOutput("rst_addr", 64'(bus.target_addr), 64'd0);
      checkOutput("rst_rw", 64'(bus.rw_flag), 64'd0);
      checkOutput("rst_wdata", 64'(bus.uart_rx_data_in), 64'd0);
      reset = 1'b1;
      waitCycles(3);
      checkOutput("idle_tx_valid", 64'(bus.tx_valid), 64'd0);

      // HALT
      applyStimulus(8'h80);
      checkOutput("halt_enable", 64'(bus.enable), 64'd0);
`ifdef WRITE_ACK_EN
      recvByte("halt_ack", 8'hA5, 0);
`else
      waitCycles(2);
      checkOutput("halt_no_tx", 64'(bus.tx_valid), 64'd0);
`endif

      // WRITE instr mem 0x123 <= 0xDEADBEEF
      reqBase = reqCount;
      applyStimulus(8'h61);
      applyStimulus(8'h23);
      applyStimulus(8'hDE);
      applyStimulus(8'hAD);
      applyStimulus(8'hBE);
      applyStimulus(8'hEF);
      waitCycles(4);
      checkOutput("wr_req_pulses", 64'(reqCount - reqBase), 64'd1);
      checkOutput("wr_type", 64'(capType), 64'd1);
      checkOutput("wr_addr", 64'(capAddr), 64'h123);
      checkOutput("wr_rw", 64'(capRw), 64'd1);
      checkOutput("wr_data", 64'(capData), 64'hDEADBEEF);
      checkOutput("wr_addr_held", 64'(bus.target_addr), 64'h123);
`ifdef WRITE_ACK_EN
      recvByte("wr_ack", 8'hA5, 0);
`else
      checkOutput("wr_no_tx", 64'(bus.tx_valid), 64'd0);
`endif

      // READ instr mem 0x005, memory answers one cycle after the request
      reqBase = reqCount;
      applyStimulus(8'h20);
      applyStimulus(8'h05);
      waitReq("rd_req_seen");
      @(negedge clk);
      bus.instr_mem_tx_data_ready = 1'b1;
      bus.instr_mem_tx_data = 42'h205_00900113;
      @(negedge clk);
      bus.instr_mem_tx_data_ready = 1'b0;
      recvByte("rd_b0", 8'h02, 3);
      recvByte("rd_b1", 8'h05, 3);
      recvByte("rd_b2", 8'h00, 3);
      recvByte("rd_b3", 8'h90, 3);
      recvByte("rd_b4", 8'h01, 3);
      recvByte("rd_b5", 8'h13, 3);
      waitCycles(2);
      checkOutput("rd_done_tx_valid", 64'(bus.tx_valid), 64'd0);
      checkOutput("rd_req_pulses", 64'(reqCount - reqBase), 64'd1);
      checkOutput("rd_type", 64'(capType), 64'd1);
      checkOutput("rd_addr", 64'(capAddr), 64'h005);
      checkOutput("rd_rw", 64'(capRw), 64'd0);

      // READ data mem 0x007: only the instr memory answers, which must be ignored
      applyStimulus(8'h00);
      applyStimulus(8'h07);
      waitReq("rdto_req_seen");
      @(negedge clk);
      bus.instr_mem_tx_data_ready = 1'b1;
      bus.instr_mem_tx_data = 42'h3FF_FFFFFFFF;
      @(negedge clk);
      bus.instr_mem_tx_data_ready = 1'b0;
      recvByte("rdto_err", 8'hEE, 0);
      checkOutput("rdto_type", 64'(capType), 64'd0);
      checkOutput("rdto_addr", 64'(capAddr), 64'h007);

      // RUN, then a READ while running is refused
      applyStimulus(8'hC0);
      checkOutput("run_enable", 64'(bus.enable), 64'd1);
`ifdef WRITE_ACK_EN
      recvByte("run_ack", 8'hA5, 0);
`endif
      reqBase = reqCount;
      applyStimulus(8'h20);
      applyStimulus(8'h05);
      recvByte("rd_running_err", 8'hEE, 0);
      checkOutput("rd_running_no_req", 64'(reqCount - reqBase), 64'd0);

      // Partial WRITE abandoned after silence; next byte is a fresh HALT
      reqBase = reqCount;
      applyStimulus(8'h40);
      applyStimulus(8'h10);
      applyStimulus(8'h01);
      waitCycles(RX_TO + 5);
      applyStimulus(8'h80);
      checkOutput("rxto_enable", 64'(bus.enable), 64'd0);
      checkOutput("rxto_no_req", 64'(reqCount - reqBase), 64'd0);
`ifdef WRITE_ACK_EN
      recvByte("rxto_halt_ack", 8'hA5, 0);
`endif

      // Byte arriving on the very cycle the inter-byte timeout is reached is kept
      reqBase = reqCount;
      applyStimulus(8'h40);
      waitCycles(RX_TO - 2);
      applyStimulus(8'h10);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      waitCycles(3);
      checkOutput("edge_req_pulses", 64'(reqCount - reqBase), 64'd1);
      checkOutput("edge_type", 64'(capType), 64'd0);
      checkOutput("edge_addr", 64'(capAddr), 64'h010);
      checkOutput("edge_data", 64'(capData), 64'h11223344);
`ifdef WRITE_ACK_EN
      recvByte("edge_ack", 8'hA5, 0);
`endif

      // Reset while an error byte is waiting for tx_ready
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      begin
         int waited = 0;
         while (bus.tx_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
         end
      end
      checkOutput("midsend_valid", 64'(bus.tx_valid), 64'd1);
      checkOutput("midsend_byte", 64'(bus.tx_byte), 64'hEE);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midsend_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
      checkOutput("midsend_rst_enable", 64'(bus.enable), 64'd1);
      checkOutput("midsend_rst_addr", 64'(bus.target_addr), 64'd0);
      reset = 1'b1;
      bus.tx_ready = 1'b1;
      waitCycles(5);
      checkOutput("midsend_no_resend", 64'(bus.tx_valid), 64'd0);
      bus.tx_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_mem_cmd_decoder.md
Name: uart_mem_cmd_decoder

Overview:
- Host-side debug front end that sits directly upstream of the instruction and data memories.
- Assembles UART rx bytes into memory read/write and CPU halt/run commands.
- Drives the memories' enable / write_mem_req / target_mem_type / target_addr / rw_flag / uart_rx_data_in interface.
- Captures the 42-bit read response ({1'b1, addr[8:0], data[31:0]}) and serializes it back to the UART transmitter as bytes.

Parameters:
- RX_TIMEOUT, 100000, idle clk cycles allowed between bytes of one packet before the partial packet is discarded.
- RD_TIMEOUT, 16, clk cycles to wait for a memory's tx_data_ready after a read request before an error byte is returned.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- rx_byte  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe, rx_byte valid
- tx_byte  output  8  byte to UART transmitter
- tx_valid  output  1  tx_byte valid; held until tx_ready
- tx_ready  input  1  transmitter accepts tx_byte when tx_valid&&tx_ready
- enable  output  1  CPU run enable; memories accept debug access only when 0
- write_mem_req  output  1  one-cycle memory access request
- target_mem_type  output  1  1=instruction memory, 0=data memory
- target_addr  output  9  word address
- rw_flag  output  1  1=write, 0=read
- uart_rx_data_in  output  32  write data
- instr_mem_tx_data_ready  input  1  instruction memory read response valid
- instr_mem_tx_data  input  42  instruction memory read response
- data_mem_tx_data_ready  input  1  data memory read response valid
- data_mem_tx_data  input  42  data memory read response

Behaviour:
- Reset (reset==0 at posedge clk):
  - outputs: enable=1, write_mem_req=0, tx_valid=0, tx_byte=0, target_mem_type=0, target_addr=0, rw_flag=0, uart_rx_data_in=0.
  - state=IDLE; counters cleared.
  - Reset mid-packet or mid-transmit abandons everything; no partial byte is re-sent.
- Packet byte0 fields:
  - [7:6] opcode: 00 READ, 01 WRITE, 10 HALT, 11 RUN.
  - [5] mem type.
  - [0] addr[8].
  - [4:1] ignored.
- Packet lengths:
  - READ: byte0, byte1=addr[7:0].
  - WRITE: byte0, byte1, then 4 data bytes, MSB first.
  - HALT/RUN: byte0 only.
- States: IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_RD, SEND.
- IDLE:
  - On rx_valid, latch byte0.
  - HALT sets enable=0 next cycle; RUN sets enable=1 next cycle; both stay in IDLE.
  - READ/WRITE go to GET_ADDR.
- GET_ADDR:
  - On rx_valid, latch addr.
  - READ goes to ISSUE; WRITE goes to GET_DATA with a 2-bit byte counter at 0.
- GET_DATA:
  - Shift in 4 bytes; after the 4th, go to ISSUE.
- ISSUE:
  - If enable==1, queue single error byte 0xEE and go to SEND; no request is issued.
  - Otherwise assert write_mem_req for exactly one cycle, with target_* / rw_flag / uart_rx_data_in stable from that cycle until the next command.
  - WRITE returns to IDLE.
  - READ goes to WAIT_RD.
- WAIT_RD:
  - Sample the ready input selected by target_mem_type; the other memory's ready is ignored.
  - On ready: latch {6'b0, tx_data[41:0]} into a 48-bit shift register, queue 6 bytes MSB first, go to SEND.
  - If RD_TIMEOUT cycles elapse without ready: queue 0xEE and go to SEND.
- SEND:
  - Present the next byte with tx_valid=1; advance only on tx_valid&&tx_ready.
  - Return to IDLE after the last byte is accepted.
  - rx_valid bytes arriving in WAIT_RD/SEND/ISSUE are dropped.
- Inter-byte timeout:
  - In GET_ADDR/GET_DATA, a counter resets on each rx_valid.
  - Reaching RX_TIMEOUT returns to IDLE with no request and no response.
- Simultaneous events: a timeout reached in the same cycle as rx_valid accepts the byte; the timeout is ignored.
- Addresses wrap naturally at 9 bits; no range check (memories truncate).

Optional Feature:
- Macro WRITE_ACK_EN.
- Defined: after a completed WRITE (request issued), HALT, or RUN, queue single byte 0xA5 and go to SEND.
- Not defined: these commands produce no UART output.
- READ and error behaviour are identical either way.

Test Plan:
- Reset then idle -> enable=1, tx_valid=0, write_mem_req=0, all address/data outputs 0.
- Send 0x80 (HALT), then 0x61 0x23 0xDE 0xAD 0xBE 0xEF -> enable=0; single write_mem_req pulse with target_mem_type=1, target_addr=0x123, rw_flag=1, uart_rx_data_in=0xDEADBEEF.
- Halted; send 0x20 0x05; model returns instr ready one cycle later with 42'h2_05_00900113 ({1,0x005,0x00900113}) -> tx bytes 0x02 0x05 0x00 0x90 0x01 0x13, with tx_ready stalled for 3 cycles between bytes.
- Send READ while enable=1 -> no write_mem_req; tx byte 0xEE. Halted READ with no ready for 16 cycles -> tx byte 0xEE.
- Send 0x40 0x10 0x01, then silence for RX_TIMEOUT cycles, then 0x80 -> no write request; enable goes to 0.
- WRITE_ACK_EN defined: HALT -> tx byte 0xA5. Assert reset mid-SEND -> tx_valid=0 next cycle, state IDLE.
